otter_csr_unit: RTL and testbench

Machine-mode CSR and interrupt unit for the OTTER RV32I core. It is the responder side of the control decoder's trap interface. It generates `INT_TAKEN`, and supplies the `MTVEC` target for `PC_SOURCE=4`, the `MEPC` target for `PC_SOURCE=5`, and CSR read data for `RF_WR_SEL=1`. It sits beside the register file, is driven by the control FSM and the decode stage, and owns `mstatus`, `mtvec`, `mepc`, `mcause` and the external-interrupt pending logic.

---
 rtl/otter_csr_pkg.sv | 48 ++++
 rtl/otter_csr_unit_intr_sync_edge.sv | 28 ++
 rtl/otter_csr_unit.sv | 130 +++++++++++++
 tb/tb_otter_csr_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_csr_pkg.sv
// Shared constants, types and helpers for the OTTER machine-mode CSR unit.
// Imported by the CSR unit top and its interrupt synchronizer.
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_MEI      = 32'h8000_000B;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    CSR_NOP = 2'd0,
    CSR_RW  = 2'd1,
    CSR_RS  = 2'd2,
    CSR_RC  = 2'd3
  } csr_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } trap_state_t;

  // New CSR value for a read-modify-write operation.
  function automatic logic [31:0] csr_apply(input csr_op_t op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] operand);
    logic [31:0] result;
    result = old_val;
    case (op)
      CSR_RW:  result = operand;
      CSR_RS:  result = old_val | operand;
      CSR_RC:  result = old_val & ~operand;
      default: result = old_val;
    endcase
    return result;
  endfunction

  // csrrs/csrrc with a zero operand are read-only accesses and must not write.
  function automatic logic csr_op_writes(input csr_op_t op, input logic [31:0] operand);
    return (op == CSR_RW) || ((op != CSR_NOP) && (operand != 32'd0));
  endfunction

endpackage

// File: rtl/otter_csr_unit_intr_sync_edge.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse on
// each rising edge of the synchronized signal.
module intr_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  // Both terms come straight from flops, so the pulse is glitch-free.
  assign rise_pulse = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/otter_csr_unit.sv
// Machine-mode CSR file and external-interrupt trap sequencer for the OTTER core.
// Owns mstatus/mtvec/mepc/mcause and raises INT_TAKEN for one cycle per trap.
module otter_csr_unit
  import otter_csr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INTR,
  input  logic        INSTR_DONE,
  input  logic        CSR_WE,
  input  logic [2:0]  FUNC3,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] WD,
  input  logic [31:0] PC,
  input  logic        MRET_EXEC,
  output logic [31:0] RD,
  output logic [31:0] MTVEC,
  output logic [31:0] MEPC,
  output logic        INT_TAKEN,
  output logic        MIE,
  output logic        ILLEGAL_CSR
);

  trap_state_t state;
  csr_op_t     op;
  logic        intr_rise;
  logic        pending;
  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] rd_val;
  logic [31:0] csr_new;
  logic        csr_hit;
  logic        csr_wr;
  logic        unused_func3_imm;

  // FUNC3[2] only selects rs1 vs zimm, which is already folded into WD.
  assign op               = csr_op_t'(FUNC3[1:0]);
  assign unused_func3_imm = FUNC3[2];

  intr_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_intr_sync (
    .clk       (CLK),
    .rst_n     (RST_N),
    .async_in  (INTR),
    .rise_pulse(intr_rise)
  );

  always_comb begin
    csr_hit = 1'b1;
    rd_val  = '0;
    case (CSR_ADDR)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = mie_q;
        rd_val[MSTATUS_MPIE] = mpie_q;
      end
      CSR_MTVEC:  rd_val = mtvec_q;
      CSR_MEPC:   rd_val = mepc_q;
      CSR_MCAUSE: rd_val = mcause_q;
      default:    csr_hit = 1'b0;
    endcase
  end

  assign csr_new = csr_apply(op, rd_val, WD);
  // The trap update owns the CSRs during TRAP, so software writes are dropped there.
  assign csr_wr  = CSR_WE && csr_hit && (state == IDLE) && csr_op_writes(op, WD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (INSTR_DONE && pending && mie_q) state <= TRAP;
        TRAP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A fresh edge during TRAP must survive the clear.
      if (intr_rise)
        pending <= 1'b1;
      else if (state == TRAP)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (state == TRAP) begin
      mepc_q   <= PC & ADDR_ALIGN_MASK;
      mcause_q <= MCAUSE_MEI;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else begin
      if (csr_wr) begin
        case (CSR_ADDR)
          CSR_MSTATUS: begin
            mie_q  <= csr_new[MSTATUS_MIE];
            mpie_q <= csr_new[MSTATUS_MPIE];
          end
          CSR_MTVEC:  mtvec_q  <= csr_new & ADDR_ALIGN_MASK;
          CSR_MEPC:   mepc_q   <= csr_new & ADDR_ALIGN_MASK;
          CSR_MCAUSE: mcause_q <= csr_new;
          default:    ;
        endcase
      end
      if (MRET_EXEC) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end
    end
  end

  assign RD          = rd_val;
  assign MTVEC       = mtvec_q;
  assign MEPC        = mepc_q;
  assign MIE         = mie_q;
  assign INT_TAKEN   = (state == TRAP);
  assign ILLEGAL_CSR = CSR_WE && !csr_hit;

endmodule

// File: tb/tb_otter_csr_unit.sv
// Scoreboard bench for otter_csr_unit: a per-cycle reference model pushes
// expected outputs, and a negedge monitor pops and compares them.
module tb_otter_csr_unit;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        intr;
  logic        instr_done;
  logic        csr_we;
  logic [2:0]  func3;
  logic [11:0] csr_addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic        mret_exec;
  logic [31:0] rd_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        int_taken_o;
  logic        mie_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  otter_csr_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .INTR       (intr),
    .INSTR_DONE (instr_done),
    .CSR_WE     (csr_we),
    .FUNC3      (func3),
    .CSR_ADDR   (csr_addr),
    .WD         (wd),
    .PC         (pc),
    .MRET_EXEC  (mret_exec),
    .RD         (rd_o),
    .MTVEC      (mtvec_o),
    .MEPC       (mepc_o),
    .INT_TAKEN  (int_taken_o),
    .MIE        (mie_o),
    .ILLEGAL_CSR(illegal_o)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie;
    logic        int_taken;
    logic        illegal;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared;
  int   n_mismatched;

  // Reference model state, kept as plain architectural values.
  bit          m_mie, m_mpie, m_pending, m_trap;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  bit          hist[$];

  function automatic bit m_implemented(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_pending = 0; m_trap = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0;
    hist.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back(1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("rd",          rd_o,               e.rd);
    check("mtvec",       mtvec_o,            e.mtvec);
    check("mepc",        mepc_o,             e.mepc);
    check("mie",         32'(mie_o),         32'(e.mie));
    check("int_taken",   32'(int_taken_o),   32'(e.int_taken));
    check("illegal_csr", 32'(illegal_o),     32'(e.illegal));
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic applyStimulus(input bit done, input bit we, input logic [2:0] f3,
                               input logic [11:0] addr, input logic [31:0] w,
                               input logic [31:0] p, input bit mret, input bit irq);
    exp_t        e;
    bit          rise, old_mie;
    logic [31:0] old_val, new_val;
    bit          do_write;
    instr_done = done; csr_we = we; func3 = f3; csr_addr = addr;
    wd = w; pc = p; mret_exec = mret; intr = irq;

    e.rd        = m_read(addr);
    e.mtvec     = m_mtvec;
    e.mepc      = m_mepc;
    e.mie       = m_mie;
    e.int_taken = m_trap;
    e.illegal   = we && !m_implemented(addr);
    sb_q.push_back(e);

    rise = hist[SYNC_STAGES-1] && !hist[SYNC_STAGES];
    if (m_trap) begin
      m_mepc    = p & ~32'h3;
      m_mcause  = 32'h8000_000B;
      m_mpie    = m_mie;
      m_mie     = 0;
      m_trap    = 0;
      m_pending = rise;
    end else begin
      old_mie  = m_mie;
      old_val  = m_read(addr);
      do_write = we && m_implemented(addr);
      case (f3[1:0])
        2'd1:    new_val = w;
        2'd2:    begin new_val = old_val | w;  if (w == 0) do_write = 0; end
        2'd3:    begin new_val = old_val & ~w; if (w == 0) do_write = 0; end
        default: begin new_val = old_val; do_write = 0; end
      endcase
      if (do_write) begin
        case (addr)
          12'h300: begin m_mie = new_val[3]; m_mpie = new_val[7]; end
          12'h305: m_mtvec  = new_val & ~32'h3;
          12'h341: m_mepc   = new_val & ~32'h3;
          default: m_mcause = new_val;
        endcase
      end
      if (mret) begin
        m_mie  = m_mpie;
        m_mpie = 1;
      end
      m_trap    = done && m_pending && old_mie;
      m_pending = m_pending || rise;
    end
    hist.push_front(irq);
    void'(hist.pop_back());

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit irq);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd0, 12'h300, 32'd0, 32'd0, 0, irq);
  endtask

  task automatic pulse_intr();
    applyStimulus(0, 0, 3'd0, 12'h300, 32'd0, 32'd0, 0, 1);
    applyStimulus(0, 0, 3'd0, 12'h300, 32'd0, 32'd0, 0, 1);
    idle(4, 0);
  endtask

  // Strobe INSTR_DONE until the model enters TRAP; returns with TRAP pending this cycle.
  task automatic run_to_trap(input logic [31:0] p, input string name);
    int budget;
    budget = 0;
    while (!m_trap && budget < 20) begin
      applyStimulus(1, 0, 3'd0, 12'h342, 32'd0, p, 0, 0);
      budget++;
    end
    if (!m_trap) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: trap not reached, got 0 traps, expected 1", name);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  initial begin
    logic [11:0] addr_tbl[6];
    bit          irq_lvl;
    n_compared = 0;
    n_mismatched = 0;
    addr_tbl = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h000};

    rst_n = 0; intr = 0; instr_done = 0; csr_we = 0; func3 = 0;
    csr_addr = 12'h300; wd = 0; pc = 0; mret_exec = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_int_taken", 32'(int_taken_o), 32'd0);
    check("reset_mtvec",     mtvec_o,          32'd0);
    check("reset_mie",       32'(mie_o),       32'd0);
    rst_n = 1;

    $display("[TB] read-before-write on mtvec");
    applyStimulus(0, 1, 3'd1, 12'h305, 32'h0000_0103, 32'd0, 0, 0);
    check("mtvec_aligned", mtvec_o, 32'h0000_0100);
    idle(1, 0);

    $display("[TB] set/clear on mstatus");
    applyStimulus(0, 1, 3'd2, 12'h300, 32'h88, 32'd0, 0, 0);
    idle(1, 0);
    applyStimulus(0, 1, 3'd3, 12'h300, 32'h08, 32'd0, 0, 0);
    idle(1, 0);
    applyStimulus(0, 1, 3'd6, 12'h300, 32'h00, 32'd0, 0, 0);
    idle(1, 0);

    $display("[TB] interrupt entry");
    applyStimulus(0, 1, 3'd2, 12'h300, 32'h08, 32'd0, 0, 0);
    pulse_intr();
    applyStimulus(1, 0, 3'd0, 12'h342, 32'd0, 32'h40, 0, 0);
    applyStimulus(0, 0, 3'd0, 12'h342, 32'd0, 32'h40, 0, 0);
    check("trap_mepc", mepc_o, 32'h40);
    check("trap_mie",  32'(mie_o), 32'd0);
    idle(1, 0);
    applyStimulus(0, 0, 3'd0, 12'h342, 32'd0, 32'd0, 0, 0);

    $display("[TB] masked interrupt is held");
    pulse_intr();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 3'd0, 12'h300, 32'd0, 32'h80, 0, 0);
    applyStimulus(0, 1, 3'd2, 12'h300, 32'h08, 32'd0, 0, 0);
    applyStimulus(1, 0, 3'd0, 12'h300, 32'd0, 32'h84, 0, 0);
    idle(3, 0);

    $display("[TB] mret and writes during trap");
    applyStimulus(0, 0, 3'd0, 12'h300, 32'd0, 32'd0, 1, 0);
    idle(1, 0);
    pulse_intr();
    run_to_trap(32'h0000_1234, "trap_for_ignore");
    applyStimulus(0, 1, 3'd1, 12'h305, 32'hABCD_0000, 32'h0000_2000, 1, 0);
    idle(1, 0);
    applyStimulus(0, 0, 3'd0, 12'h300, 32'd0, 32'd0, 1, 0);
    idle(1, 0);

    $display("[TB] illegal address");
    applyStimulus(0, 1, 3'd1, 12'h7C0, 32'hFFFF_FFFF, 32'd0, 0, 0);
    idle(1, 0);
    applyStimulus(0, 0, 3'd0, 12'h305, 32'd0, 32'd0, 0, 0);

    $display("[TB] randomized traffic");
    irq_lvl = 0;
    for (int i = 0; i < 600; i++) begin
      bit          we, mret, done;
      logic [11:0] a;
      logic [31:0] w;
      we   = ($urandom_range(0, 9) < 3);
      mret = !we && ($urandom_range(0, 19) == 0);
      done = ($urandom_range(0, 9) < 4);
      a    = addr_tbl[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0:       w = 32'd0;
        1:       w = 32'h88;
        2:       w = 32'h08;
        default: w = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) irq_lvl = !irq_lvl;
      applyStimulus(done, we, 3'($urandom_range(0, 7)), a, w, $urandom & ~32'h3, mret, irq_lvl);
    end
    idle(4, 0);

    $display("[TB] reset asserted mid-trap");
    applyStimulus(0, 1, 3'd1, 12'h300, 32'h08, 32'd0, 0, 0);
    pulse_intr();
    run_to_trap(32'h0000_0ABC, "trap_before_reset");
    @(negedge clk);
    check("pre_reset_int_taken", 32'(int_taken_o), 32'd1);
    rst_n = 0;
    #1;
    check("rst_int_taken", 32'(int_taken_o), 32'd0);
    check("rst_mepc",      mepc_o,           32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check("post_rst_mepc", mepc_o, 32'd0);
    idle(3, 0);
    applyStimulus(0, 0, 3'd0, 12'h341, 32'd0, 32'd0, 0, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
